// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - state_t   : controller state, 4-bit encoded
//   - OP_*      : supported opcodes
//   - ALU_*, SRCB_*, PCSRC_* : encodings of alu_op, alu_src_b and pc_src
//   - op_supported() : true for opcodes the controller can sequence
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_MEMWB  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode
// Purely combinational decoder from controller state to datapath controls.
// Ports:
//   state      in  state_t  current controller state
//   op         in  6        opcode (only used for illegal_op in DECODE)
//   mem_ok     in  1        memory ready (already forced to 1 if stalls disabled)
//   zero       in  1        ALU zero flag (branch decision)
//   enable     in  1        0 forces every write strobe and illegal_op low
//   pc_en .. illegal_op out  datapath control lines
module mc_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ok,
  input  logic       zero,
  input  logic       enable,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op
);

  logic pc_en_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic illegal_raw;

  always_comb begin
    pc_en_raw     = 1'b0;
    iord          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_src        = PCSRC_ALU;
    illegal_raw   = 1'b0;
    unique case (state)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        // PC+4 and IR load only commit in the cycle the fetch completes
        ir_write_raw = mem_ok;
        pc_en_raw    = mem_ok;
      end
      S_DECODE: begin
        alu_src_b   = SRCB_IMM_SH2;
        illegal_raw = !op_supported(op);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en_raw = zero;
      end
      S_JUMP: begin
        pc_src    = PCSRC_JUMP;
        pc_en_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset has to kill strobes immediately, even while FETCH would otherwise
  // pass mem_ready straight through to ir_write/pc_en.
  assign pc_en      = pc_en_raw     & enable;
  assign mem_write  = mem_write_raw & enable;
  assign ir_write   = ir_write_raw  & enable;
  assign reg_write  = reg_write_raw & enable;
  assign illegal_op = illegal_raw   & enable;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle MIPS control FSM: holds the state register and next-state
// logic; control outputs come from mc_out_decode.
// Parameters:
//   WAIT_ON_MEM  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: never wait
// Ports:
//   clk, rst_n (async assert, active low), op, zero, mem_ready  inputs
//   pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
//   alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], illegal_op  outputs
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_ON_MEM = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op
);

  state_t state_reg;
  state_t state_next;
  logic   mem_ok;

  assign mem_ok = (WAIT_ON_MEM == 0) ? 1'b1 : mem_ready;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_FETCH:  if (mem_ok) state_next = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR and the IR is not reloaded meanwhile.
      S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ok) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ok) state_next = S_FETCH;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  mc_out_decode u_out_decode (
    .state      (state_reg),
    .op         (op),
    .mem_ok     (mem_ok),
    .zero       (zero),
    .enable     (rst_n),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [14:0] got;

  int n_cmp = 0;
  int n_err = 0;
  int n_instr = 0;

  multicycle_control #(.WAIT_ON_MEM(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  // Expected control word, fields in the same order as 'got'.
  function automatic logic [14:0] vec(
      input logic pe, input logic io, input logic mw, input logic irw,
      input logic rw, input logic rd, input logic m2r, input logic asa,
      input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] ps,
      input logic ill);
    return {pe, io, mw, irw, rw, rd, m2r, asa, asb, aop, ps, ill};
  endfunction

  typedef struct {
    logic        mr;
    logic        z;
    logic [14:0] exp;
  } cyc_t;

  cyc_t q[$];

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(input logic mr, input logic z, input logic [14:0] e);
    cyc_t c;
    c.mr = mr; c.z = z; c.exp = e;
    return c;
  endfunction

  // Reference: per-instruction cycle script straight from the control table.
  // fs = fetch wait cycles, ms = memory wait cycles, zf = 0/1 forced, 2 random.
  task automatic build(input logic [5:0] o, input int fs, input int ms, input int zf);
    logic z;
    for (int i = 0; i < fs; i++)
      q.push_back(mk(1'b0, rbit(), vec(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)));
    q.push_back(mk(1'b1, rbit(), vec(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,0)));
    case (o)
      6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02:
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0)));
      default:
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1)));
    endcase
    case (o)
      6'h23: begin
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0)));
        for (int i = 0; i < ms; i++)
          q.push_back(mk(1'b0, rbit(), vec(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0)));
        q.push_back(mk(1'b1, rbit(), vec(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0)));
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0)));
      end
      6'h2B: begin
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0)));
        for (int i = 0; i < ms; i++)
          q.push_back(mk(1'b0, rbit(), vec(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0)));
        q.push_back(mk(1'b1, rbit(), vec(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0)));
      end
      6'h00: begin
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0)));
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0)));
      end
      6'h08: begin
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0)));
        q.push_back(mk(rbit(), rbit(), vec(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0)));
      end
      6'h04: begin
        z = (zf == 2) ? rbit() : 1'(zf);
        q.push_back(mk(rbit(), z, vec(z,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0)));
      end
      6'h02:
        q.push_back(mk(rbit(), rbit(), vec(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0)));
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [14:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  // Plays 'limit' cycles of the queued script (all if limit < 0).
  task automatic run(input logic [5:0] o, input int limit);
    int n;
    int cycles;
    n = (limit < 0) ? q.size() : limit;
    cycles = 0;
    n_instr++;
    for (int i = 0; i < n; i++) begin
      cyc_t c;
      c = q.pop_front();
      @(negedge clk);
      if (i == 0) op = o;  // DUT is in FETCH here; op is not sampled
      mem_ready = c.mr;
      zero = c.z;
      #1;
      chk($sformatf("instr%0d_op%02h_cyc%0d", n_instr, o, i + 1), c.exp);
      cycles++;
    end
    q.delete();
    $display("instr %0d op=%02h cycles=%0d", n_instr, o, cycles);
  endtask

  task automatic do_instr(input logic [5:0] o, input int fs, input int ms, input int zf);
    build(o, fs, ms, zf);
    run(o, -1);
  endtask

  logic [14:0] rst_vec;
  logic [5:0]  legal_ops [6];
  logic [5:0]  rop;

  initial begin
    legal_ops[0] = 6'h00; legal_ops[1] = 6'h23; legal_ops[2] = 6'h2B;
    legal_ops[3] = 6'h04; legal_ops[4] = 6'h08; legal_ops[5] = 6'h02;
    rst_vec = vec(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);

    // Reset held 3 cycles with mem_ready high: strobes stay low.
    rst_n = 1'b0; op = 6'h23; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("reset_hold%0d", i), rst_vec);
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Directed sequence from the test plan.
    do_instr(6'h23, 0, 0, 2);   // lw, 5 cycles
    do_instr(6'h00, 0, 0, 2);   // R-type, 4 cycles
    do_instr(6'h2B, 0, 2, 2);   // sw with 2 wait cycles, 6 cycles
    do_instr(6'h04, 0, 0, 1);   // beq taken
    do_instr(6'h04, 0, 0, 0);   // beq not taken
    do_instr(6'h02, 0, 0, 2);   // j
    do_instr(6'h3F, 0, 0, 2);   // illegal
    do_instr(6'h08, 1, 0, 2);   // addi with a fetch stall
    do_instr(6'h23, 2, 3, 2);   // lw with fetch and read stalls

    // Reset during MEMWB: reg_write must drop at once, state back to FETCH.
    build(6'h23, 0, 0, 2);
    run(6'h23, 5);
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset_in_memwb", rst_vec);
    @(negedge clk); #1 chk("reset_after_memwb", rst_vec);
    @(posedge clk); #2 rst_n = 1'b1;
    do_instr(6'h00, 0, 0, 2);   // must restart from FETCH

    // Reset during a MEMWR wait: mem_write must drop at once.
    build(6'h2B, 0, 3, 2);
    run(6'h2B, 4);
    #1 rst_n = 1'b0;
    #1 chk("reset_in_memwr", rst_vec);
    @(posedge clk); #2 rst_n = 1'b1;
    do_instr(6'h04, 0, 0, 2);

    // Randomised instruction stream.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        rop = 6'($urandom_range(0, 63));
        while (rop == 6'h00 || rop == 6'h23 || rop == 6'h2B ||
               rop == 6'h04 || rop == 6'h08 || rop == 6'h02)
          rop = 6'($urandom_range(0, 63));
      end else begin
        rop = legal_ops[$urandom_range(0, 5)];
      end
      do_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
